// File: rtl/hazard_sequencer_pkg.sv
// Shared pipeline package: hazard FSM encodings, sequencer defaults and
// control-unit opcode constants.
package hazard_sequencer_pkg;

  localparam int DEF_CNT_W    = 16;
  localparam int DEF_MAX_WAIT = 15;
  localparam int WAIT_W       = 4;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_LU_STALL = 2'b01,
    ST_MEM_WAIT = 2'b10,
    ST_FLUSH    = 2'b11
  } hz_state_e;

  // RV32I major opcodes used by the control unit.
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic pc_hold;
    logic ifid_hold;
    logic ifid_flush;
    logic idex_hold;
    logic idex_flush;
    logic exmem_hold;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_NONE     = 6'b000000;
  localparam hz_ctrl_t CTRL_MEMSTALL = 6'b110101;
  localparam hz_ctrl_t CTRL_REDIRECT = 6'b001010;
  localparam hz_ctrl_t CTRL_BUBBLE   = 6'b110010;

  // x0 is never a real producer, so a load to x0 cannot create a hazard.
  function automatic logic is_load_use(
    input logic       ex_mem_read,
    input logic [4:0] ex_rd,
    input logic       use_rs1,
    input logic [4:0] rs1,
    input logic       use_rs2,
    input logic [4:0] rs2
  );
    return ex_mem_read && (ex_rd != 5'd0) &&
           ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));
  endfunction

endpackage

// File: rtl/hazard_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module hazard_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: load-use bubbles, redirect flushes, memory-wait
// holds, with stall/flush performance counters and a sticky memory timeout.
module hazard_sequencer
  import hazard_sequencer_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memRead,
  input  logic             ex_branch_taken,
  input  logic             ex_jump,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             clr_counts,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_hold,
  output logic             idex_flush,
  output logic             exmem_hold,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_timeout
);

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  hz_state_e         state_q;
  hz_state_e         state_d;
  hz_ctrl_t          ctrl;
  logic              loaduse;
  logic              redirect;
  logic              memstall;
  logic              mem_waiting;
  logic [WAIT_W-1:0] wait_cnt;

  assign loaduse  = is_load_use(ex_memRead, ex_rd, id_use_rs1, id_rs1,
                                id_use_rs2, id_rs2);
  assign redirect = ex_branch_taken | ex_jump;
  assign memstall = mem_req & ~mem_ready;

  assign mem_waiting = (state_q == ST_MEM_WAIT) && !mem_ready;

  // Shared priority: memstall > redirect > loaduse. In LU_STALL the EX stage
  // holds the bubble we just inserted, so its load-use match is stale.
  always_comb begin
    ctrl    = CTRL_NONE;
    state_d = ST_RUN;
    case (state_q)
      ST_MEM_WAIT: begin
        if (!mem_ready) begin
          ctrl    = CTRL_MEMSTALL;
          state_d = ST_MEM_WAIT;
        end else if (redirect) begin
          ctrl    = CTRL_REDIRECT;
          state_d = ST_FLUSH;
        end else if (loaduse) begin
          ctrl    = CTRL_BUBBLE;
          state_d = ST_LU_STALL;
        end
      end
      ST_LU_STALL: begin
        if (memstall) begin
          ctrl    = CTRL_MEMSTALL;
          state_d = ST_MEM_WAIT;
        end else if (redirect) begin
          ctrl    = CTRL_REDIRECT;
          state_d = ST_FLUSH;
        end
      end
      default: begin
        if (memstall) begin
          ctrl    = CTRL_MEMSTALL;
          state_d = ST_MEM_WAIT;
        end else if (redirect) begin
          ctrl    = CTRL_REDIRECT;
          state_d = ST_FLUSH;
        end else if (loaduse) begin
          ctrl    = CTRL_BUBBLE;
          state_d = ST_LU_STALL;
        end
      end
    endcase
    if (!rst_n) begin
      ctrl = CTRL_NONE;
    end
  end

  assign pc_hold    = ctrl.pc_hold;
  assign ifid_hold  = ctrl.ifid_hold;
  assign ifid_flush = ctrl.ifid_flush;
  assign idex_hold  = ctrl.idex_hold;
  assign idex_flush = ctrl.idex_flush;
  assign exmem_hold = ctrl.exmem_hold;
  assign state      = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // The wait counter parks at the limit; another stalled cycle from there
  // means the limit has been exceeded and the timeout latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      if (!mem_waiting) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WAIT_LIMIT) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (clr_counts) begin
        mem_timeout <= 1'b0;
      end else if (mem_waiting && (wait_cnt == WAIT_LIMIT)) begin
        mem_timeout <= 1'b1;
      end
    end
  end

  hazard_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_counts),
    .inc   (ctrl.pc_hold),
    .count (stall_count)
  );

  hazard_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_counts),
    .inc   (ctrl.ifid_flush),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed scenarios plus random
// stimulus checked against a rule-level reference model.
module tb_hazard_sequencer;

  localparam int CNT_W    = 16;
  localparam int MAX_WAIT = 15;
  localparam int CMAX     = (1 << CNT_W) - 1;

  // Control vector order: pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_hold
  localparam logic [5:0] HOLD_ALL   = 6'b110101;
  localparam logic [5:0] FLUSH_BOTH = 6'b001010;
  localparam logic [5:0] BUBBLE     = 6'b110010;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [4:0]       id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic             id_use_rs1 = 0, id_use_rs2 = 0, ex_memRead = 0;
  logic             ex_branch_taken = 0, ex_jump = 0, mem_req = 0, mem_ready = 0;
  logic             clr_counts = 0;
  logic             pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_hold;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_count, flush_count;
  logic             mem_timeout;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         m_mode;
  int         m_wait_n;
  int         m_stall;
  int         m_flush;
  bit         m_timeout;
  logic [5:0] last_ctrl;

  hazard_sequencer #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .ex_rd           (ex_rd),
    .ex_memRead      (ex_memRead),
    .ex_branch_taken (ex_branch_taken),
    .ex_jump         (ex_jump),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .clr_counts      (clr_counts),
    .pc_hold         (pc_hold),
    .ifid_hold       (ifid_hold),
    .ifid_flush      (ifid_flush),
    .idex_hold       (idex_hold),
    .idex_flush      (idex_flush),
    .exmem_hold      (exmem_hold),
    .state           (state),
    .stall_count     (stall_count),
    .flush_count     (flush_count),
    .mem_timeout     (mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] ctrlNow();
    return {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_hold};
  endfunction

  // Called at posedge+1; drives one cycle, checks the combinational controls
  // mid-cycle, then the registered outputs just after the next edge.
  task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic [4:0] rd,
                               input logic mr, input logic br, input logic jp,
                               input logic mq, input logic my, input logic cl);
    logic       lu, redir, ms, stalled_wait;
    logic [5:0] exp_ctrl;
    int         next_mode;
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2; ex_rd = rd;
    ex_memRead = mr; ex_branch_taken = br; ex_jump = jp;
    mem_req = mq; mem_ready = my; clr_counts = cl;
    #3;
    lu    = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    redir = br || jp;
    ms    = mq && !my;
    stalled_wait = (m_mode == 2) && !my;
    exp_ctrl  = 6'b0;
    next_mode = 0;
    if (stalled_wait || ms) begin
      exp_ctrl = HOLD_ALL; next_mode = 2;
    end else if (redir) begin
      exp_ctrl = FLUSH_BOTH; next_mode = 3;
    end else if (lu && m_mode != 1) begin
      exp_ctrl = BUBBLE; next_mode = 1;
    end
    last_ctrl = ctrlNow();
    checkOutput("ctrl", 32'(last_ctrl), 32'(exp_ctrl));
    @(posedge clk);
    #1;
    if (stalled_wait) begin
      m_wait_n++;
      if (m_wait_n > MAX_WAIT) m_timeout = 1;
    end else begin
      m_wait_n = 0;
    end
    if (cl) begin
      m_stall = 0; m_flush = 0; m_timeout = 0;
    end else begin
      if (exp_ctrl[5] && m_stall < CMAX) m_stall++;
      if (exp_ctrl[3] && m_flush < CMAX) m_flush++;
    end
    m_mode = next_mode;
    checkOutput("state", 32'(state), 32'(m_mode));
    checkOutput("stall_count", 32'(stall_count), 32'(m_stall));
    checkOutput("flush_count", 32'(flush_count), 32'(m_flush));
    checkOutput("mem_timeout", 32'(mem_timeout), 32'(m_timeout));
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  // Reset mid-cycle with every hazard input active; controls must drop at once.
  task automatic doReset();
    id_rs1 = 5'd5; id_use_rs1 = 1; ex_rd = 5'd5; ex_memRead = 1;
    ex_branch_taken = 1; mem_req = 1; mem_ready = 0;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_ctrl", 32'(ctrlNow()), 32'd0);
    checkOutput("rst_state", 32'(state), 32'd0);
    checkOutput("rst_stall", 32'(stall_count), 32'd0);
    checkOutput("rst_flush", 32'(flush_count), 32'd0);
    checkOutput("rst_timeout", 32'(mem_timeout), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("rst_hold_ctrl", 32'(ctrlNow()), 32'd0);
    id_rs1 = 0; id_use_rs1 = 0; ex_rd = 0; ex_memRead = 0;
    ex_branch_taken = 0; ex_jump = 0; mem_req = 0; mem_ready = 1; clr_counts = 0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_mode = 0; m_wait_n = 0; m_stall = 0; m_flush = 0; m_timeout = 0;
    checkOutput("post_rst_state", 32'(state), 32'd0);
    checkOutput("post_rst_stall", 32'(stall_count), 32'd0);
  endtask

  initial begin
    m_mode = 0; m_wait_n = 0; m_stall = 0; m_flush = 0; m_timeout = 0;
    @(posedge clk);
    #1;
    doReset();

    // Load x5 in EX, ID reads x5: one bubble, then back to RUN.
    applyStimulus(5, 0, 1, 0, 5, 1, 0, 0, 0, 1, 0);
    checkOutput("lu_ctrl", 32'(last_ctrl), 32'(BUBBLE));
    checkOutput("lu_state", 32'(state), 32'd1);
    idle();
    checkOutput("lu_back_run", 32'(state), 32'd0);
    checkOutput("lu_stall_count", 32'(stall_count), 32'd1);

    // Load to x0 is never a hazard.
    applyStimulus(0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0);
    checkOutput("x0_state", 32'(state), 32'd0);

    // Taken branch together with a load-use: flush only.
    doReset();
    applyStimulus(7, 0, 1, 0, 7, 1, 1, 0, 0, 1, 0);
    checkOutput("br_ctrl", 32'(last_ctrl), 32'(FLUSH_BOTH));
    checkOutput("br_state", 32'(state), 32'd3);
    checkOutput("br_flush", 32'(flush_count), 32'd1);
    checkOutput("br_stall", 32'(stall_count), 32'd0);
    idle();

    // 20 cycles of memory wait, then ready with a jump in EX.
    doReset();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      checkOutput("mw_holds", 32'(last_ctrl), 32'(HOLD_ALL));
    end
    checkOutput("mw_timeout", 32'(mem_timeout), 32'd1);
    checkOutput("mw_stall", 32'(stall_count), 32'd20);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
    checkOutput("mw_release", 32'(last_ctrl), 32'(FLUSH_BOTH));
    checkOutput("mw_timeout_sticky", 32'(mem_timeout), 32'd1);

    // Reset in the middle of MEM_WAIT and of LU_STALL.
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    doReset();
    applyStimulus(3, 0, 1, 0, 3, 1, 0, 0, 0, 1, 0);
    doReset();
    idle();
    checkOutput("no_pending_stall", 32'(state), 32'd0);

    // Drive stall_count to saturation, then clear alongside a stall.
    doReset();
    for (int i = 0; i < CMAX + 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("sat_stall", 32'(stall_count), 32'hFFFF);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    checkOutput("clr_wins", 32'(stall_count), 32'd0);
    checkOutput("clr_timeout", 32'(mem_timeout), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    // Random traffic with small register indices so hazards are frequent.
    doReset();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        doReset();
      end else begin
        applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
                      1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 31) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 Parameter CNT_W, default 16: width of the performance counters.
REQ-002 Parameter MAX_WAIT, default 15: memory-wait cycles allowed before mem_timeout is raised.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 id_rs1, id_rs2  in  5 each  source registers of the ID-stage instruction.
REQ-006 id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1 / rs2.
REQ-007 ex_rd  in  5  destination register of the EX-stage instruction.
REQ-008 ex_memRead  in  1  EX instruction is a load.
REQ-009 ex_branch_taken, ex_jump  in  1 each  EX resolves a taken branch / jump (redirect).
REQ-010 mem_req  in  1  MEM stage holds a load/store; mem_ready  in  1  data memory completes it this cycle.
REQ-011 clr_counts  in  1  synchronous clear of counters and mem_timeout.
REQ-012 pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_hold  out  1 each  pipeline register controls.
REQ-013 state  out  2  FSM state: RUN=00, LU_STALL=01, MEM_WAIT=10, FLUSH=11.
REQ-014 stall_count, flush_count  out  CNT_W each; mem_timeout  out  1  sticky.

Function
REQ-015 Control outputs SHALL be combinational from state and inputs; state, counters and mem_timeout SHALL be registered.
REQ-016 loaduse = ex_memRead AND ex_rd!=0 AND ((id_use_rs1 AND id_rs1==ex_rd) OR (id_use_rs2 AND id_rs2==ex_rd)).
REQ-017 redirect = ex_branch_taken OR ex_jump.
REQ-018 memstall = mem_req AND NOT mem_ready.
REQ-019 Priority in RUN, LU_STALL and FLUSH: memstall > redirect > loaduse.
REQ-020 memstall SHALL assert pc_hold, ifid_hold, idex_hold, exmem_hold and no flush; next state MEM_WAIT.
REQ-021 redirect without memstall SHALL assert ifid_flush and idex_flush in the same cycle; next state FLUSH.
REQ-022 loaduse alone SHALL assert pc_hold, ifid_hold and idex_flush (one bubble); next state LU_STALL.
REQ-023 LU_STALL and FLUSH SHALL last exactly one cycle and return to RUN unless a new event fires per REQ-019.
REQ-024 In LU_STALL, loaduse SHALL be ignored because EX holds a bubble.
REQ-025 MEM_WAIT with mem_ready=0 SHALL keep all four holds asserted.
REQ-026 MEM_WAIT with mem_ready=1 SHALL release the holds that cycle, evaluate redirect and loaduse as in RUN, and transition accordingly.
REQ-027 A 4-bit internal wait counter SHALL count MEM_WAIT cycles and clear on exit.
REQ-028 When the wait counter exceeds MAX_WAIT, mem_timeout SHALL set and stay set until clr_counts or reset; waiting continues.
REQ-029 stall_count SHALL increment in every cycle where pc_hold=1.
REQ-030 flush_count SHALL increment once per redirect cycle.
REQ-031 Both counters SHALL saturate at all-ones.
REQ-032 clr_counts SHALL take priority over increments in the same cycle.
REQ-033 A redirect together with loaduse SHALL count as flush only, not stall.

Reset
REQ-034 While rst_n=0: state=RUN, counters=0, wait counter=0, mem_timeout=0.
REQ-035 While rst_n=0, all hold and flush outputs SHALL be 0 regardless of inputs.
REQ-036 Reset asserted mid-MEM_WAIT or mid-LU_STALL SHALL abort the sequence immediately, with no pending stall after release.

Structure
REQ-037 State encodings and the CNT_W / MAX_WAIT defaults SHALL live in the shared pipeline package, next to the control-unit opcode constants.
REQ-038 One sub-module, hazard_sat_counter (saturating counter with clear), SHALL be instantiated twice.

Verification
REQ-039 Load x5 in EX (ex_rd=5, ex_memRead=1), ID add with id_rs1=5 -> one cycle of pc_hold=ifid_hold=idex_flush=1; state 01 then 00; stall_count=1.
REQ-040 Load to x0 with id_rs1=0 -> no stall; state stays 00.
REQ-041 ex_branch_taken=1 with loaduse=1 -> ifid_flush=idex_flush=1, pc_hold=0; state 11; flush_count=1; stall_count=0.
REQ-042 mem_req=1, mem_ready held 0 for 20 cycles -> all holds asserted 20 cycles; mem_timeout rises after wait counter passes 15; on mem_ready=1 with ex_jump=1, same cycle holds drop and both flushes assert.
REQ-043 rst_n pulled low during MEM_WAIT -> outputs 0 immediately; after release state=00, counters 0.
REQ-044 stall_count preloaded near all-ones by sustained stalls -> saturates at 16'hFFFF; clr_counts plus a stall in the same cycle -> reads 0.
